// File: rtl/neuron_pkg.sv
// Shared constants for the two-input fixed-point neuron: default widths,
// accumulator width and the saturation bounds of the output format.
package neuron_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_FRAC_W = 8;

  // p1 + p2 of two 2*DATA_W products needs one extra bit to never overflow
  localparam int ACC_W = 2 * DEF_DATA_W + 1;

  localparam logic signed [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic signed [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

endpackage

// File: rtl/neuron_sat.sv
// Combinational signed saturator: clamps a wide two's-complement value into
// the representable range of a narrower signed output.
module neuron_sat
  import neuron_pkg::*;
#(
  parameter int IN_W  = ACC_W,
  parameter int OUT_W = DEF_DATA_W
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  // Output bounds expressed in the input width for a signed compare
  localparam logic signed [IN_W-1:0]  MAX_EXT = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0]  MIN_EXT = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic signed [OUT_W-1:0] MAX_OUT = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_OUT = {1'b1, {(OUT_W-1){1'b0}}};

  // Clamp to the output range; in-range values pass through by truncation
  always_comb begin
    dout = din[OUT_W-1:0];
    if (din > MAX_EXT) begin
      dout = MAX_OUT;
    end else if (din < MIN_EXT) begin
      dout = MIN_OUT;
    end else begin
      dout = din[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/neuron.sv
// Two-input fixed-point neuron: y = act(W1*x1 + W2*x2 + BIAS), two-stage
// pipeline, one sample per cycle, no backpressure.
// Build option: define NEURON_RELU_EN for a ReLU activation; otherwise the
// activation is linear (saturated value passes straight through).
module neuron
  import neuron_pkg::*;
#(
  parameter int                       DATA_W = DEF_DATA_W,
  parameter int                       FRAC_W = DEF_FRAC_W,
  parameter logic signed [DATA_W-1:0] W1     = 16'sh0080,
  parameter logic signed [DATA_W-1:0] W2     = 16'sh0040,
  parameter logic signed [DATA_W-1:0] BIAS   = 16'sh0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] x1,
  input  logic signed [DATA_W-1:0] x2,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] y
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int ACC_W_L = PROD_W + 1;

  localparam logic signed [PROD_W-1:0]  W1_EXT   = {{DATA_W{W1[DATA_W-1]}}, W1};
  localparam logic signed [PROD_W-1:0]  W2_EXT   = {{DATA_W{W2[DATA_W-1]}}, W2};
  localparam logic signed [ACC_W_L-1:0] BIAS_EXT = {{(ACC_W_L-DATA_W){BIAS[DATA_W-1]}}, BIAS};

  logic signed [PROD_W-1:0]  x1_ext_s;
  logic signed [PROD_W-1:0]  x2_ext_s;
  logic signed [PROD_W-1:0]  p1_r;
  logic signed [PROD_W-1:0]  p2_r;
  logic                      v1_r;
  logic signed [ACC_W_L-1:0] s_s;
  logic signed [ACC_W_L-1:0] t_s;
  logic signed [ACC_W_L-1:0] u_s;
  logic signed [DATA_W-1:0]  sat_s;
  logic signed [DATA_W-1:0]  act_s;
  logic signed [DATA_W-1:0]  y_r;
  logic                      out_valid_r;

  // Sign-extend inputs so the products are formed at full width
  assign x1_ext_s = {{DATA_W{x1[DATA_W-1]}}, x1};
  assign x2_ext_s = {{DATA_W{x2[DATA_W-1]}}, x2};

  // Stage 1: register both weighted products; data loads only on a valid sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_r <= {PROD_W{1'b0}};
      p2_r <= {PROD_W{1'b0}};
      v1_r <= 1'b0;
    end else begin
      v1_r <= in_valid;
      if (in_valid) begin
        p1_r <= x1_ext_s * W1_EXT;
        p2_r <= x2_ext_s * W2_EXT;
      end
    end
  end

  // Stage 2 arithmetic: exact sum, floor rescale by FRAC_W, then bias
  always_comb begin
    s_s = {p1_r[PROD_W-1], p1_r} + {p2_r[PROD_W-1], p2_r};
    t_s = s_s >>> FRAC_W;
    u_s = t_s + BIAS_EXT;
  end

  neuron_sat #(
    .IN_W  (ACC_W_L),
    .OUT_W (DATA_W)
  ) u_sat (
    .din  (u_s),
    .dout (sat_s)
  );

  // Activation applied after saturation so no wrapped value can reach y
  always_comb begin
    act_s = sat_s;
`ifdef NEURON_RELU_EN
    if (sat_s[DATA_W-1] == 1'b1) begin
      act_s = {DATA_W{1'b0}};
    end else begin
      act_s = sat_s;
    end
`else
    act_s = sat_s;
`endif
  end

  // Output register: y updates only with a valid result and holds otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_r         <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= v1_r;
      if (v1_r) begin
        y_r <= act_s;
      end
    end
  end

  assign y         = y_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_neuron.sv
// Self-checking bench for neuron: three instances (default weights,
// W1=2.0, BIAS=100) share one stimulus stream and are compared every cycle
// against an arithmetic reference model.
module tb_neuron;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] x1 = 16'sd0;
  logic signed [15:0] x2 = 16'sd0;
  logic               ov [3];
  logic signed [15:0] yv [3];

  int checks = 0;
  int errors = 0;

  // Per-instance configuration used by the reference model
  int cfg_w1   [3] = '{128, 512, 128};
  int cfg_w2   [3] = '{64, 64, 64};
  int cfg_bias [3] = '{0, 0, 100};

  // Expected state: result of the sample driven in the previous step, last held y
  logic prev_v = 1'b0;
  int   prev_y [3];
  int   last_y [3];

  always #5 clk = ~clk;

  neuron #(.W1(16'sh0080), .W2(16'sh0040), .BIAS(16'sh0000)) u_n0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x1(x1), .x2(x2),
    .out_valid(ov[0]), .y(yv[0]));
  neuron #(.W1(16'sh0200), .W2(16'sh0040), .BIAS(16'sh0000)) u_n1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x1(x1), .x2(x2),
    .out_valid(ov[1]), .y(yv[1]));
  neuron #(.W1(16'sh0080), .W2(16'sh0040), .BIAS(16'sd100)) u_n2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x1(x1), .x2(x2),
    .out_valid(ov[2]), .y(yv[2]));

  // Reference: real-valued weighted sum, floor to integer, bias, clamp, activation
  function automatic int ref_y(int a, int b, int w1, int w2, int bias);
    longint s, t, u;
    s = longint'(a) * longint'(w1) + longint'(b) * longint'(w2);
    if (s >= 0) t = s / 256;
    else        t = -((-s + 255) / 256);
    u = t + longint'(bias);
    if (u > 32767)       u = 32767;
    else if (u < -32768) u = -32768;
`ifdef NEURON_RELU_EN
    if (u < 0) u = 0;
`endif
    return int'(u);
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock step: drive a sample, clock it, then compare all instances
  task automatic step(input string tag, input logic v,
                      input logic signed [15:0] a, input logic signed [15:0] b);
    in_valid = v;
    x1 = a;
    x2 = b;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("%s_ov%0d", tag, i), {31'd0, ov[i]}, {31'd0, prev_v});
      if (prev_v) last_y[i] = prev_y[i];
      check($sformatf("%s_y%0d", tag, i), yv[i], last_y[i]);
    end
    prev_v = v;
    for (int i = 0; i < 3; i++) prev_y[i] = ref_y(a, b, cfg_w1[i], cfg_w2[i], cfg_bias[i]);
  endtask

  task automatic reset_model();
    prev_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      prev_y[i] = 0;
      last_y[i] = 0;
    end
  endtask

  initial begin
    logic signed [15:0] ra, rb;
    logic rv;
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ov%0d", i), {31'd0, ov[i]}, 32'sd0);
      check($sformatf("rst_y%0d", i), yv[i], 32'sd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults: 1000, 2000 -> 1000 two cycles later
    step("t2a", 1'b1, 16'sd1000, 16'sd2000);
    step("t2b", 1'b0, 16'sd0, 16'sd0);
    check("t2_n0_const", yv[0], 32'sd1000);
    step("t2c", 1'b0, 16'sd0, 16'sd0);

    // Floor rounding on a negative result
    step("t3a", 1'b1, -16'sd3, 16'sd0);
    step("t3b", 1'b0, 16'sd0, 16'sd0);
`ifdef NEURON_RELU_EN
    check("t3_n0_const", yv[0], 32'sd0);
`else
    check("t3_n0_const", yv[0], -32'sd2);
`endif

    // Saturation at both rails (instance 1 has W1 = 2.0)
    step("t4a", 1'b1, 16'sd32767, 16'sd32767);
    step("t4b", 1'b1, -16'sd32768, -16'sd32768);
    check("t4_n1_max", yv[1], 32'sd32767);
    step("t4c", 1'b0, 16'sd0, 16'sd0);
`ifdef NEURON_RELU_EN
    check("t4_n1_min", yv[1], 32'sd0);
`else
    check("t4_n1_min", yv[1], -32'sd32768);
`endif

    // Bias only, then three back-to-back samples
    step("t5a", 1'b1, 16'sd0, 16'sd0);
    step("t5b", 1'b1, 16'sd400, -16'sd800);
    check("t5_n2_bias", yv[2], 32'sd100);
    step("t5c", 1'b1, -16'sd1234, 16'sd5678);
    step("t5d", 1'b1, 16'sd20000, 16'sd20000);
    step("t5e", 1'b0, 16'sd0, 16'sd0);
    step("t5f", 1'b0, 16'sd0, 16'sd0);

    // Randomized stream, occasionally at the input extremes
    for (int n = 0; n < 300; n++) begin
      rv = ($urandom_range(3, 0) != 0);
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(7, 0) == 0) ra = ($urandom_range(1, 0) != 0) ? 16'sh7fff : 16'sh8000;
      if ($urandom_range(7, 0) == 0) rb = ($urandom_range(1, 0) != 0) ? 16'sh7fff : 16'sh8000;
      step("rnd", rv, ra, rb);
    end

    // Reset mid-stream with samples in flight
    step("mr_a", 1'b1, 16'sd3000, 16'sd100);
    step("mr_b", 1'b1, -16'sd700, 16'sd900);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("mr_ov%0d", i), {31'd0, ov[i]}, 32'sd0);
      check($sformatf("mr_y%0d", i), yv[i], 32'sd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    reset_model();
    for (int n = 0; n < 3; n++) step("post_rst", 1'b0, 16'sd0, 16'sd0);
    step("post_a", 1'b1, 16'sd1000, 16'sd2000);
    step("post_b", 1'b0, 16'sd0, 16'sd0);
    step("post_c", 1'b0, 16'sd0, 16'sd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
